// File: rtl/spi_slave_shifter_if.sv
// Signal bundle between the SCK/CS edge detector plus host logic and the SPI slave bit engine.
// The slave modport is the bit engine. The master modport is whatever drives it: the edge detector, the host and the bench.
interface spi_slave_shifter_if #(
  parameter int SPI_MAX_WIDTH_LOG = 4
);
  localparam int MAXW = 1 << SPI_MAX_WIDTH_LOG;

  // Handshake: there is no valid/ready flow control. Every strobe is a one-cycle pulse.
  //   Inputs:  sck_first_edge, sck_second_edge, spi_start, spi_finish.
  //   Outputs: tx_load, rx_valid, frame_err.
  //   rx_data is qualified by rx_valid and is held until the next completed frame.
  logic                         cpha;
  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width;
  logic                         sck_first_edge;
  logic                         sck_second_edge;
  logic                         spi_start;
  logic                         spi_finish;
  logic                         mosi;
  logic [MAXW-1:0]              tx_data;
  logic                         miso;
  logic                         tx_load;
  logic [MAXW-1:0]              rx_data;
  logic                         rx_valid;
  logic                         frame_err;
  logic                         busy;

  modport slave (
    input  cpha, spi_width, sck_first_edge, sck_second_edge, spi_start, spi_finish, mosi, tx_data,
    output miso, tx_load, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output cpha, spi_width, sck_first_edge, sck_second_edge, spi_start, spi_finish, mosi, tx_data,
    input  miso, tx_load, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI slave bit engine: shifts MOSI in and MISO out, MSB first, under CPHA and a per-frame width.
// o_state exposes the FSM state (0 = IDLE, 1 = ACTIVE, 2 = DONE).
module spi_slave_shifter #(
  parameter int SPI_MAX_WIDTH_LOG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_slave_shifter_if.slave  bus,
  output logic [1:0]          o_state
);
  localparam int MAXW = 1 << SPI_MAX_WIDTH_LOG;
  localparam int CW   = SPI_MAX_WIDTH_LOG + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_cpha;
  logic [SPI_MAX_WIDTH_LOG-1:0] r_width;
  logic [CW-1:0]                r_cnt;
  logic [MAXW-1:0]              r_rx_sh;
  logic [MAXW-1:0]              r_tx_sh;
  logic [MAXW-1:0]              r_rx_data;
  logic                         r_first_done;
  logic                         r_tx_load;
  logic                         r_rx_valid;
  logic                         r_frame_err;

  logic                         w_sample;
  logic                         w_drive;
  logic [CW-1:0]                w_cnt_nxt;
  logic [CW-1:0]                w_frame_len;
  logic [MAXW-1:0]              w_rx_sh_nxt;
  logic [SPI_MAX_WIDTH_LOG-1:0] w_shamt;
  logic                         w_rx_valid;
  logic                         w_frame_err;

  // Sample and drive edges only count in ACTIVE and never together with a restart.
  assign w_sample    = (r_state == S_ACTIVE) && !bus.spi_start &&
                       (r_cpha ? bus.sck_second_edge : bus.sck_first_edge);
  assign w_drive     = (r_state == S_ACTIVE) && !bus.spi_start &&
                       (r_cpha ? bus.sck_first_edge : bus.sck_second_edge);
  assign w_cnt_nxt   = r_cnt + CNT_ONE;
  assign w_frame_len = {1'b0, r_width} + CNT_ONE;
  assign w_rx_sh_nxt = {r_rx_sh[MAXW-2:0], bus.mosi};
  // MAXW-W equals the bitwise inverse of spi_width because MAXW is a power of two.
  assign w_shamt     = ~bus.spi_width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.spi_start) begin
      w_state_nxt = S_ACTIVE;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (w_rx_valid)          w_state_nxt = bus.spi_finish ? S_IDLE : S_DONE;
          else if (bus.spi_finish) w_state_nxt = S_IDLE;
        end
        S_DONE:   if (bus.spi_finish) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rx_valid  = 1'b0;
    w_frame_err = 1'b0;
    if (w_sample && (w_cnt_nxt == w_frame_len)) w_rx_valid = 1'b1;
    if ((r_state == S_ACTIVE) && bus.spi_finish && !bus.spi_start && !w_rx_valid)
      w_frame_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpha       <= 1'b0;
      r_width      <= '0;
      r_cnt        <= '0;
      r_rx_sh      <= '0;
      r_tx_sh      <= '0;
      r_rx_data    <= '0;
      r_first_done <= 1'b0;
      r_tx_load    <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_tx_load   <= bus.spi_start;
      r_rx_valid  <= w_rx_valid;
      r_frame_err <= w_frame_err;
      if (bus.spi_start) begin
        r_cpha       <= bus.cpha;
        r_width      <= bus.spi_width;
        r_cnt        <= '0;
        r_rx_sh      <= '0;
        r_tx_sh      <= bus.tx_data << w_shamt;
        r_first_done <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_sh <= w_rx_sh_nxt;
          r_cnt   <= w_cnt_nxt;
        end
        if (w_rx_valid) r_rx_data <= w_rx_sh_nxt;
        // Emptying the transmit shifter at frame end keeps miso low in DONE and IDLE.
        if (w_rx_valid || w_frame_err) begin
          r_tx_sh <= '0;
        end else if (w_drive) begin
          if (r_cpha && !r_first_done) r_first_done <= 1'b1;
          else                         r_tx_sh <= {r_tx_sh[MAXW-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.miso      = r_tx_sh[MAXW-1];
  assign bus.tx_load   = r_tx_load;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);
  assign o_state       = r_state;
endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a scoreboard queue of expected rx events plus per-frame MISO and status checks.
module tb_spi_slave_shifter;
  localparam int LOG  = 4;
  localparam int MAXW = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] o_state;
  int         checks = 0;
  int         errors = 0;
  logic [17:0] exp_q[$];   // {frame_err, rx_valid, rx_data}

  spi_slave_shifter_if #(.SPI_MAX_WIDTH_LOG(LOG)) bus ();

  spi_slave_shifter #(.SPI_MAX_WIDTH_LOG(LOG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid or frame_err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got err=%b valid=%b data=0x%0h expected none",
                 bus.frame_err, bus.rx_valid, bus.rx_data);
      end else begin
        check("rx_event", {14'd0, bus.frame_err, bus.rx_valid, bus.rx_data}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic sck_period(input bit cp, input bit m, input bit fin, output bit so);
    so = 1'b0;
    @(negedge clk);
    bus.mosi = m;
    bus.sck_first_edge = 1'b1;
    if (!cp) begin
      so = bus.miso;
      bus.spi_finish = fin;
    end
    @(negedge clk);
    bus.sck_first_edge = 1'b0;
    bus.spi_finish = 1'b0;
    if (fin && !cp) return;
    repeat (2) @(negedge clk);
    bus.sck_second_edge = 1'b1;
    if (cp) begin
      so = bus.miso;
      bus.spi_finish = fin;
    end
    @(negedge clk);
    bus.sck_second_edge = 1'b0;
    bus.spi_finish = 1'b0;
    if (!fin) repeat (2) @(negedge clk);
  endtask

  task automatic start_frame(input bit cp, input logic [3:0] wm1, input logic [15:0] txd);
    @(negedge clk);
    bus.cpha = cp;
    bus.spi_width = wm1;
    bus.tx_data = txd;
    bus.spi_start = 1'b1;
    @(negedge clk);
    bus.spi_start = 1'b0;
    check("tx_load_after_start", {31'd0, bus.tx_load}, 32'd1);
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("state_active", {30'd0, o_state}, 32'd1);
    // Scramble the frame setup; only the values latched at start may matter.
    bus.cpha = ~cp;
    bus.spi_width = ~wm1;
    bus.tx_data = ~txd;
  endtask

  task automatic run_frame(input bit cp, input logic [3:0] wm1, input logic [15:0] txd,
                           input logic [15:0] mo, input int nper, input bit fin_last,
                           input logic [1:0] st_end, input logic [15:0] exp_miso,
                           input logic [17:0] exp_ev);
    logic [15:0] cap;
    bit so;
    exp_q.push_back(exp_ev);
    start_frame(cp, wm1, txd);
    cap = '0;
    for (int k = 0; k < nper; k++) begin
      sck_period(cp, mo[nper-1-k], fin_last && (k == nper-1), so);
      cap = {cap[14:0], so};
    end
    check("miso_bits", {16'd0, cap}, {16'd0, exp_miso});
    if (!fin_last) begin
      check("state_before_finish", {30'd0, o_state}, {30'd0, st_end});
      @(negedge clk);
      bus.spi_finish = 1'b1;
      @(negedge clk);
      bus.spi_finish = 1'b0;
    end
    check("busy_after_finish", {31'd0, bus.busy}, 32'd0);
    check("miso_idle", {31'd0, bus.miso}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {31'd0, bus.miso}, 32'd0);
    check({tag, "_tx_load"}, {31'd0, bus.tx_load}, 32'd0);
    check({tag, "_rx_data"}, {16'd0, bus.rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_state"}, {30'd0, o_state}, 32'd0);
  endtask

  initial begin
    bit so;
    rst_n = 1'b0;
    bus.cpha = 1'b0;
    bus.spi_width = '0;
    bus.sck_first_edge = 1'b0;
    bus.sck_second_edge = 1'b0;
    bus.spi_start = 1'b0;
    bus.spi_finish = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // cpha=0, 8-bit frame
    run_frame(1'b0, 4'd7, 16'h003C, 16'h00A5, 8, 1'b0, 2'd2, 16'h003C, 18'h100A5);
    // cpha=1, 16-bit frame
    run_frame(1'b1, 4'd15, 16'h8001, 16'h1234, 16, 1'b0, 2'd2, 16'h8001, 18'h11234);
    // truncated after 3 samples: frame_err, rx_data keeps 0x1234
    run_frame(1'b0, 4'd7, 16'h00FF, 16'h0005, 3, 1'b0, 2'd1, 16'h0007, 18'h21234);
    // 4-bit frame with 6 SCK periods: extra edges ignored, miso 0 after completion
    run_frame(1'b1, 4'd3, 16'h000A, 16'h0035, 6, 1'b0, 2'd2, 16'h0028, 18'h1000D);
    // 1-bit frame whose sample coincides with CS rise
    run_frame(1'b0, 4'd0, 16'h0001, 16'h0001, 1, 1'b1, 2'd0, 16'h0001, 18'h10001);

    // reset mid-frame: no event expected, outputs back to reset values
    start_frame(1'b0, 4'd7, 16'h0055);
    for (int k = 0; k < 3; k++) sck_period(1'b0, 1'b1, 1'b0, so);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 4'd7, 16'h00C3, 16'h005A, 8, 1'b0, 2'd2, 16'h00C3, 18'h1005A);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
